// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Handles load-use, EX redirects, MEM wait states and timeout halt.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  wb_bubble,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t          state;
  logic [WW-1:0]   waitCnt;
  logic            isHalt;
  logic            memWait;
  logic            redirect;
  logic            rsHit;
  logic            loadUse;

  assign isHalt = (state == HALT);

  assign memWait =
    ((state == RUN) && mem_req && !mem_ready) ||
    ((state == MEM_WAIT) && !mem_ready);

  assign redirect = !isHalt && !memWait &&
    ex_branch_taken;

  assign rsHit =
    (id_uses_rs1 && (id_rs1 == ex_rd)) ||
    (id_uses_rs2 && (id_rs2 == ex_rd));

  // A redirect squashes the ID instruction, so no load-use stall.
  assign loadUse = !isHalt && !memWait &&
    !ex_branch_taken && ex_mem_read &&
    (ex_rd != '0) && rsHit;

  assign halted = isHalt;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    wb_bubble = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        isHalt || memWait: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end
        redirect: begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end
        loadUse: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      stall_count <= '0;
    end else begin
      if (stall_if && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      unique case (state)
        RUN: begin
          if (memWait) begin
            state   <= MEM_WAIT;
            waitCnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WW'(TIMEOUT - 1)) begin
            state <= HALT;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. Each cycle it decides which pipeline registers hold (IF/ID, ID/EX, EX/MEM, MEM/WB) and which receive a bubble. Inputs are load-use hazards, taken branches resolved in EX, and data-memory wait states in MEM. It also keeps a memory-wait FSM with a timeout-to-halt and a saturating stall-cycle counter.

## Interface
Parameters
- REG_ADDR_W, 5, register-index width
- TIMEOUT, 16, max consecutive MEM wait cycles before halt (≥2)
- CNT_W, 32, stall counter width

Ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold PC+IF/ID, ID/EX, EX/MEM, MEM/WB sources respectively
- flush_id  out  1  load bubble into IF/ID at next edge
- flush_ex  out  1  load bubble into ID/EX at next edge
- wb_bubble  out  1  MEM/WB captures registerWriteEnable=0 at next edge
- halted  out  1  controller in HALT (memory timeout), sticky until rst
- stall_count  out  CNT_W  total cycles with stall_if=1, saturating

## Operation
- States: RUN, MEM_WAIT, HALT. Reset → RUN.
- Decision outputs are combinational from state and inputs. State, wait_cnt and stall_count are registered.
- While rst=1, all decision outputs are 0.
- Priority, highest first: HALT > memory wait > branch redirect > load-use.
- Memory wait is active in RUN when mem_req=1 and mem_ready=0, and in MEM_WAIT when mem_ready=0.
  - Outputs: stall_if=stall_id=stall_ex=stall_mem=1, wb_bubble=1, flush_id=flush_ex=0.
  - In RUN the next state is MEM_WAIT and wait_cnt←1.
- MEM_WAIT with mem_ready=1: treat as RUN for this cycle, with no wait stall and branch/load-use evaluated normally. Next state RUN.
- MEM_WAIT with mem_ready=0:
  - If wait_cnt==TIMEOUT-1, next state is HALT.
  - Otherwise wait_cnt←wait_cnt+1.
- HALT: all four stalls=1, wb_bubble=1. Ignores all inputs; exits only on rst.
- Branch redirect (ex_branch_taken=1, no memory wait): flush_id=1, flush_ex=1, all stalls 0. It suppresses load-use, because the ID instruction is on the wrong path.
- Load-use occurs when all of the following hold: no wait, no redirect, ex_mem_read=1, ex_rd≠0, and (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd).
  - Outputs: stall_if=stall_id=1, flush_ex=1, stall_ex=stall_mem=0, wb_bubble=0.
- mem_req=1 with mem_ready=1 in RUN produces no stall.
- In MEM_WAIT, ex_branch_taken and load-use are ignored. EX is frozen, so they re-present once the wait ends.
- Output invariant: a flush is never asserted together with the stall of the same register.
- Counters:
  - stall_count increments on each cycle with stall_if=1, including HALT, and saturates at all-ones.
  - wait_cnt is internal, REG width ceil(log2(TIMEOUT))+1.

## Timing
- Decisions take effect at the same-cycle rising edge (zero-cycle latency from inputs to outputs).
- Load-use inserts exactly one bubble: on the next cycle the load is in MEM and the hazard clears.
- Redirect costs 2 bubbles (IF/ID and ID/EX).
- A memory access with N wait cycles (mem_ready low for N cycles after mem_req) stalls for N cycles; the pipeline advances on the cycle mem_ready=1.
- HALT is entered at the edge ending the TIMEOUT-th consecutive cycle with mem_ready=0.
- rst mid-wait or in HALT: next state RUN, wait_cnt=0, stall_count=0, halted=0.

## Test plan
- Load-use on rs2: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of stall_if=stall_id=flush_ex=1, stall_count=1. Same stimulus with ex_rd=0 → no stall.
- Taken branch coincident with load-use hazard: ex_branch_taken=1 → flush_id=flush_ex=1, stall_if=0, stall_count unchanged.
- Memory wait of 3 cycles: mem_req=1, mem_ready=0,0,0 then 1 → 3 cycles of all stalls plus wb_bubble, release on the 4th cycle, stall_count=3. Branch asserted during the wait → flush only after release.
- Timeout with TIMEOUT=4: mem_ready held 0 → halted=1 after the 4th wait cycle; outputs frozen stalled; stall_count keeps incrementing; rst → halted=0, stall_count=0, state RUN.
- Zero-wait access: mem_req=1, mem_ready=1 → no stall, state stays RUN.
- Saturation with CNT_W=3: 10 stall cycles → stall_count=7.
